// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Issues in-order word reads to instruction memory and buffers the responses
// in a small FIFO that feeds decode. Redirects from execute flush the buffer
// and discard stale in-flight responses.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps into HALT).
//
// Handshakes:
//   imem_re/imem_addr : a request is accepted in the same cycle imem_re is high.
//                       Responses return in order on imem_rvalid/imem_rdata,
//                       one word per cycle.
//   run_out/stall     : run_out is valid. stall is not-ready. An entry is
//                       consumed on a rising edge where run_out && !stall.
//                       While stall is high, insn/pc/run_out are held.
module fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_re,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       insn,
  output logic [ADDR_W-1:0] pc,
  output logic              run_out,
  output logic              fetch_misalign,
  output logic [1:0]        state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
`endif

  state_t state, state_nx;

  logic [ADDR_W-1:0] fetch_pc;

  // Instruction buffer (data only; occupancy lives in count)
  logic [31:0]       fifo_insn [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  // pc tags of live (non-stale) outstanding requests, in issue order
  logic [ADDR_W-1:0] tag_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  tag_rd, tag_wr;

  // outstanding counts every request in flight, stale or not;
  // discard counts how many of the oldest ones are stale.
  logic [CNT_W-1:0]  outstanding, discard;

  logic              deq, issue, resp, fifo_write, halted, bad_target;
  logic [CNT_W:0]    budget;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign halted     = (state == S_HALT);
  assign bad_target = redirect_en && (redirect_pc[1:0] != 2'b00);
`else
  assign halted     = 1'b0;
  assign bad_target = 1'b0;
`endif

  // Issue/response/dequeue qualifiers
  always_comb begin
    run_out    = (count != '0);
    deq        = run_out && !stall;
    budget     = {1'b0, outstanding} + {1'b0, count} - (CNT_W+1)'(deq);
    issue      = (state == S_FETCH) && !redirect_en && (budget < DEPTH_V);
    resp       = imem_rvalid && (outstanding != '0);
    fifo_write = resp && (discard == '0) && !redirect_en && !halted;
  end

  assign imem_re   = issue;
  assign imem_addr = fetch_pc;
  assign insn      = run_out ? fifo_insn[rd_ptr] : 32'h0;
  assign pc        = run_out ? fifo_pc[rd_ptr]   : '0;
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (enable) state_nx = S_FETCH;
      S_FETCH: if (!enable) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (enable)                                        state_nx = S_FETCH;
        else if ((outstanding == '0) && (count == '0))     state_nx = S_IDLE;
      end
      default: state_nx = state;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (bad_target) state_nx = S_HALT;
`endif
  end

  // Fetch address: redirect target (word aligned) or sequential advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           fetch_pc <= RESET_PC;
    else if (redirect_en) fetch_pc <= redirect_pc & ~ADDR_W'(3);
    else if (issue)       fetch_pc <= fetch_pc + ADDR_W'(4);
  end

  // Buffer data write
  always_ff @(posedge clk) begin
    if (fifo_write) begin
      fifo_insn[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= tag_q[tag_rd];
    end
  end

  // Record the pc of every issued request
  always_ff @(posedge clk) begin
    if (issue) tag_q[tag_wr] <= fetch_pc;
  end

  // Pointers and counters; a redirect flushes the buffer and marks all
  // requests still in flight after this cycle's response as stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_en) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      tag_rd      <= tag_wr;
      discard     <= outstanding - CNT_W'(resp);
      outstanding <= outstanding - CNT_W'(resp);
    end else begin
      if (fifo_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq)        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(fifo_write) - CNT_W'(deq);
      if (issue)      tag_wr <= tag_wr + PTR_W'(1);
      if (fifo_write) tag_rd <= tag_rd + PTR_W'(1);
      if (resp && (discard != '0)) discard <= discard - CNT_W'(1);
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          fetch_misalign <= 1'b0;
    else if (bad_target) fetch_misalign <= 1'b1;
  end
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage. It produces the insn/pc/run stream consumed by the decode stage and honours that stage's stall backpressure. It issues in-order word reads to instruction memory, which may have variable latency. Responses are buffered in a small FIFO, and the unit flushes and restarts on branch/jump redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2); also the bound on outstanding-plus-buffered requests
ADDR_W, 32, pc/address width

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
enable  input  1  start/continue fetching
stall  input  1  decode backpressure; head is held while 1
redirect_en  input  1  one-cycle pulse from execute: branch taken / jal / jalr
redirect_pc  input  ADDR_W  new fetch target
imem_re  output  1  read request, accepted the same cycle
imem_addr  output  ADDR_W  word-aligned request address
imem_rvalid  input  1  in-order read response valid
imem_rdata  input  32  response data
insn  output  32  instruction at FIFO head
pc  output  ADDR_W  pc of insn
run_out  output  1  insn/pc valid for decode
fetch_misalign  output  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - Outputs: imem_re=0, imem_addr=RESET_PC, run_out=0, insn=0, pc=0, fetch_misalign=0.
  - Reset asserted mid-operation abandons all in-flight requests. Responses arriving after reset release are not dropped, so the bench must not return them.
- States:
  - IDLE: no requests. Goes to FETCH on the first edge with enable=1.
  - FETCH: issues requests. Goes to DRAIN when enable=0.
  - DRAIN: no new requests; responses are still accepted and the FIFO still drains. Goes back to FETCH if enable=1, or to IDLE once outstanding==0 and the FIFO is empty.
  - HALT: only with the optional feature.
- Issue:
  - In FETCH, imem_re=1 when outstanding + count - deq < FIFO_DEPTH and redirect_en=0 (combinational).
  - imem_addr=fetch_pc. fetch_pc advances by 4 on each issue and wraps modulo 2^ADDR_W.
- Response: in order. If discard>0, decrement discard and drop the word. Otherwise write {imem_rdata, pc_of_request} into the FIFO. The request pc is tracked in a pc-tag queue alongside outstanding.
- Output:
  - run_out = FIFO non-empty; insn/pc come from the head register.
  - Dequeue when run_out && !stall.
  - While stall=1, insn/pc/run_out are held stable.
  - Latency: enable sampled at edge N gives imem_re in cycle N+1. A 1-cycle memory returns rvalid in N+2, and run_out rises in N+3.
  - With a 1-cycle memory and stall=0: one instruction per cycle.
- Redirect (redirect_en=1 at edge):
  - FIFO flushed; run_out=0 the next cycle.
  - discard = outstanding after this cycle's response (a response arriving in the same cycle is dropped).
  - fetch_pc=redirect_pc with bits[1:0] cleared. No issue in the redirect cycle.
  - Redirect takes priority over stall, dequeue and enable deassert.
  - A redirect in IDLE only loads fetch_pc.
- Counters: outstanding saturates at FIFO_DEPTH by construction. Issue and response in the same cycle leave it unchanged.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 (sticky until reset), flushes as for a normal redirect, and enters HALT. HALT issues nothing, discards remaining responses and holds run_out=0 until reset.
- Not defined: the low bits are silently cleared, fetch_misalign is tied 0, and HALT does not exist.

Test Plan:
- 1-cycle memory returning rdata=addr^32'hA5A5_0000, enable=1, stall=0 -> run_out continuous from cycle 3; pc sequence 0,4,8,12 with matching insn; imem_re high every FETCH cycle.
- Stall held 3 cycles while pc=8 at head -> insn/pc stay 8 for 4 cycles; imem_re drops once 4 entries are buffered; no loss, next pc=12.
- Memory latency 3, two requests in flight (0x10, 0x14), redirect_pc=0x100 -> both stale responses dropped; next run_out has pc=0x100, then 0x104.
- Redirect in the same cycle as rvalid and stall=1 -> FIFO empty next cycle, run_out=0, response dropped, first post-redirect pc=redirect target.
- enable dropped with 2 outstanding -> no new imem_re; both responses are delivered to decode; state returns to IDLE; re-enable resumes at the next sequential pc.
- FETCH_MISALIGN_TRAP_EN defined, redirect_pc=0x102 -> fetch_misalign=1, run_out=0, imem_re=0 until reset. Without the macro: fetching resumes at 0x100.
